// File: rtl/psum_drain_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : psum_drain_ctrl
// Description : Drains accumulated partial-sum words from psum memory port 1.
//               It can zero-clear each drained word and applies per-lane
//               ReLU. Words stream out through a credit-controlled show-ahead
//               FIFO over a valid/ready interface.
// Revision    : 1.0 - initial release
//==============================================================================
module psum_drain_ctrl #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int MEM_DELAY  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [REG_WIDTH-1:0]  i_conf_base_addr,
    input  logic [REG_WIDTH-1:0]  i_conf_num_words,
    input  logic                  i_conf_relu_en,
    input  logic                  i_conf_clear_en,
    output logic [ADDR_WIDTH-1:0] memctrl1_radd,
    output logic                  memctrl1_rden,
    input  logic [DATA_WIDTH-1:0] memctrl1_odat,
    input  logic                  memctrl1_ovld,
    output logic [ADDR_WIDTH-1:0] memctrl1_wadd,
    output logic                  memctrl1_wren,
    output logic [DATA_WIDTH-1:0] memctrl1_idat,
    output logic [DATA_WIDTH-1:0] o_dat,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [REG_WIDTH-1:0]  r_num;
    logic [REG_WIDTH-1:0]  r_issued;
    logic                  r_relu;
    logic                  r_clear;
    logic [c_cnt_w-1:0]    r_outst;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_ptr_w-1:0]    r_wptr;
    logic [c_ptr_w-1:0]    r_rptr;
    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_apipe [MEM_DELAY];
    logic [ADDR_WIDTH-1:0] r_wadd;
    logic                  r_wren;

    logic                  w_active;
    logic                  w_credit;
    logic                  w_rden;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last_issue;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic [c_cnt_w-1:0]    w_out_nxt;
    logic [DATA_WIDTH-1:0] w_lane_dat;

    // Returns are only meaningful while a drain is in progress; anything
    // arriving in IDLE/DONE is a leftover from before a reset.
    assign w_active     = (r_state == c_st_run) || (r_state == c_st_flush);
    assign w_credit     = ({1'b0, r_count} + {1'b0, r_outst}) < c_depth;
    assign w_rden       = (r_state == c_st_run) && (r_issued < r_num) && w_credit;
    assign w_push       = memctrl1_ovld && w_active;
    assign w_pop        = o_vld && i_rdy;
    assign w_last_issue = w_rden && ((r_issued + REG_WIDTH'(1)) == r_num);
    assign w_cnt_nxt    = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_out_nxt    = r_outst + c_cnt_w'(w_rden) - c_cnt_w'(w_push);

    // Per-lane ReLU: a negative signed lane is clamped to zero.
    generate
        for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
            logic [BIT_WIDTH-1:0] w_lane;
            assign w_lane = memctrl1_odat[BIT_WIDTH*k +: BIT_WIDTH];
            assign w_lane_dat[BIT_WIDTH*k +: BIT_WIDTH] =
                (r_relu && w_lane[BIT_WIDTH-1]) ? '0 : w_lane;
        end
    endgenerate

    assign memctrl1_radd = r_ptr;
    assign memctrl1_rden = w_rden;
    assign memctrl1_wadd = r_wadd;
    assign memctrl1_wren = r_wren;
    assign memctrl1_idat = '0;
    assign o_vld         = (r_count != '0);
    assign o_dat         = o_vld ? r_fifo[r_rptr] : '0;
    assign o_busy        = (r_state != c_st_idle);
    assign o_done        = (r_state == c_st_done);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic. FLUSH looks at next-cycle occupancy so that DONE
    // lands on the cycle right after the final pop and final clear write.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (i_start) w_state_nxt = (i_conf_num_words == '0) ? c_st_done : c_st_run;
            c_st_run:   if (w_last_issue) w_state_nxt = c_st_flush;
            c_st_flush: if ((w_cnt_nxt == '0) && (w_out_nxt == '0)) w_state_nxt = c_st_done;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Configuration latch, read pointer, issue and outstanding counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_num    <= '0;
            r_issued <= '0;
            r_relu   <= 1'b0;
            r_clear  <= 1'b0;
            r_outst  <= '0;
        end else begin
            r_outst <= w_out_nxt;
            if ((r_state == c_st_idle) && i_start) begin
                r_ptr    <= ADDR_WIDTH'(i_conf_base_addr);
                r_num    <= i_conf_num_words;
                r_issued <= '0;
                r_relu   <= i_conf_relu_en;
                r_clear  <= i_conf_clear_en;
            end else if (w_rden) begin
                r_ptr    <= r_ptr + ADDR_WIDTH'(1);
                r_issued <= r_issued + REG_WIDTH'(1);
            end
        end
    end

    // FIFO storage; contents beyond the pointers are never observed.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= w_lane_dat;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
            if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
            r_count <= w_cnt_nxt;
        end
    end

    // Address pipeline: delays the read address to line up with ovld.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DELAY; i++) r_apipe[i] <= '0;
        end else begin
            r_apipe[0] <= r_ptr;
            for (int i = 1; i < MEM_DELAY; i++) r_apipe[i] <= r_apipe[i-1];
        end
    end

    // Clear write-back one cycle after each accepted return.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wadd <= '0;
            r_wren <= 1'b0;
        end else begin
            r_wren <= w_push && r_clear;
            if (w_push && r_clear) r_wadd <= r_apipe[MEM_DELAY-1];
        end
    end

    // The credit rule must keep a return from ever landing on a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && ({1'b0, r_count} == c_depth)));

endmodule
`default_nettype wire

// File: tb/tb_psum_drain_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_psum_drain_ctrl
// Description : Directed self-checking bench for psum_drain_ctrl. Instance A
//               uses MEM_DELAY=1 and instance B uses MEM_DELAY=2 under
//               random backpressure.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_psum_drain_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A signals
    logic        a_start = 1'b0, a_relu = 1'b0, a_clr = 1'b0, a_rdy = 1'b1;
    logic [31:0] a_base = '0, a_num = '0;
    logic [31:0] a_radd, a_wadd, a_idat, a_dat;
    logic        a_rden, a_wren, a_vld, a_busy, a_done;
    logic [31:0] a_odat = '0;
    logic        a_ovld = 1'b0;

    // Instance B signals
    logic        b_start = 1'b0, b_rdy = 1'b1;
    logic [31:0] b_base = '0, b_num = '0;
    logic [31:0] b_radd, b_wadd, b_idat, b_dat;
    logic        b_rden, b_wren, b_vld, b_busy, b_done;
    logic [31:0] b_odat = '0, b_odat1 = '0;
    logic        b_ovld = 1'b0, b_ovld1 = 1'b0;

    psum_drain_ctrl u_dut_a (
        .clk(clk), .rst(rst), .i_start(a_start),
        .i_conf_base_addr(a_base), .i_conf_num_words(a_num),
        .i_conf_relu_en(a_relu), .i_conf_clear_en(a_clr),
        .memctrl1_radd(a_radd), .memctrl1_rden(a_rden),
        .memctrl1_odat(a_odat), .memctrl1_ovld(a_ovld),
        .memctrl1_wadd(a_wadd), .memctrl1_wren(a_wren), .memctrl1_idat(a_idat),
        .o_dat(a_dat), .o_vld(a_vld), .i_rdy(a_rdy),
        .o_busy(a_busy), .o_done(a_done)
    );

    psum_drain_ctrl #(.MEM_DELAY(2), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .i_start(b_start),
        .i_conf_base_addr(b_base), .i_conf_num_words(b_num),
        .i_conf_relu_en(1'b0), .i_conf_clear_en(1'b0),
        .memctrl1_radd(b_radd), .memctrl1_rden(b_rden),
        .memctrl1_odat(b_odat), .memctrl1_ovld(b_ovld),
        .memctrl1_wadd(b_wadd), .memctrl1_wren(b_wren), .memctrl1_idat(b_idat),
        .o_dat(b_dat), .o_vld(b_vld), .i_rdy(b_rdy),
        .o_busy(b_busy), .o_done(b_done)
    );

    // Memory model: preset content plus any words written back by clears.
    bit          written [0:255];
    logic [31:0] wval    [0:255];

    function automatic logic [31:0] init_word(input logic [7:0] a);
        if (a >= 8'h10 && a < 8'h18) return 32'h01020304 + {24'd0, a - 8'h10};
        if (a == 8'h40) return 32'h80FF7F01;
        if (a == 8'h41) return 32'h7F80017F;
        return {8'hA5, a, ~a, a};
    endfunction

    function automatic logic [31:0] rd_word(input logic [7:0] a);
        return written[a] ? wval[a] : init_word(a);
    endfunction

    // Memory ports: 1-cycle read for A, 2-cycle read for B; never reset.
    always @(posedge clk) begin
        a_ovld  <= a_rden;
        a_odat  <= rd_word(a_radd[7:0]);
        b_ovld1 <= b_rden;
        b_odat1 <= rd_word(b_radd[7:0]);
        b_ovld  <= b_ovld1;
        b_odat  <= b_odat1;
        if (a_wren) begin written[a_wadd[7:0]] <= 1'b1; wval[a_wadd[7:0]] <= a_idat; end
        if (b_wren) begin written[b_wadd[7:0]] <= 1'b1; wval[b_wadd[7:0]] <= b_idat; end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, act, exp);
    endtask

    // Per-drain observations of instance A
    int          k, n_rden, n_wren, n_pop, n_done, done_k, first_pop_k, last_pop_k, n_bad_idat;
    logic        busy_at1, rden_at1, busy_after;
    logic [31:0] radd_at1;
    logic [31:0] pops[$];
    logic [31:0] wadds[$];

    function automatic logic [31:0] pop_at(input int i);
        return (i < pops.size()) ? pops[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] wadd_at(input int i);
        return (i < wadds.size()) ? wadds[i] : 32'hxxxxxxxx;
    endfunction

    task automatic clear_stats();
        n_rden = 0; n_wren = 0; n_pop = 0; n_done = 0; done_k = -1;
        first_pop_k = -1; last_pop_k = -1; n_bad_idat = 0;
        busy_after = 1'bx;
        pops.delete(); wadds.delete();
    endtask

    task automatic observe_a();
        if (a_rden) n_rden++;
        if (a_wren) begin
            n_wren++;
            wadds.push_back(a_wadd);
            if (a_idat != 32'd0) n_bad_idat++;
        end
        if (a_vld && a_rdy) begin
            pops.push_back(a_dat);
            if (n_pop == 0) first_pop_k = k;
            last_pop_k = k;
            n_pop++;
        end
        if (a_done) begin n_done++; done_k = k; end
    endtask

    // One drain on A; start is sampled at the edge ending cycle T, k counts
    // cycles after T. A second start is pulsed at cycle dup_k (0 = none).
    task automatic drain_a(input logic [31:0] base, input logic [31:0] num,
                           input logic relu, input logic clr, input int dup_k);
        clear_stats();
        a_base = base; a_num = num; a_relu = relu; a_clr = clr; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        k = 1;
        busy_at1 = a_busy; rden_at1 = a_rden; radd_at1 = a_radd;
        while (k < 200) begin
            observe_a();
            if (k == dup_k) begin a_start = 1'b1; a_base = 32'h80; a_num = 32'd3; end
            else a_start = 1'b0;
            if (n_done != 0 && k > done_k) begin busy_after = a_busy; break; end
            @(posedge clk); #1;
            k++;
        end
        a_start = 1'b0;
    endtask

    initial begin
        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_radd", a_radd, 32'd0);
        check("rst_wadd", a_wadd, 32'd0);
        check("rst_idat", a_idat, 32'd0);
        check("rst_odat", a_dat, 32'd0);
        check("rst_ctl",  {27'd0, a_rden, a_wren, a_vld, a_busy, a_done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- basic 8-word drain ----------------
        drain_a(32'h10, 32'd8, 1'b0, 1'b0, 0);
        check("t1_busy_t1", {31'd0, busy_at1}, 32'd1);
        check("t1_rden_t1", {31'd0, rden_at1}, 32'd1);
        check("t1_radd_t1", radd_at1, 32'h10);
        check("t1_n_rden", n_rden, 8);
        check("t1_n_pop", n_pop, 8);
        for (int i = 0; i < 8; i++) check("t1_dat", pop_at(i), 32'h01020304 + i);
        check("t1_first_pop", first_pop_k, 3);
        check("t1_last_pop", last_pop_k, 10);
        check("t1_n_done", n_done, 1);
        check("t1_done_k", done_k, 11);
        check("t1_busy_after", {31'd0, busy_after}, 32'd0);

        // ---------------- start while busy is ignored ----------------
        drain_a(32'h10, 32'd4, 1'b0, 1'b0, 2);
        check("dup_n_rden", n_rden, 4);
        check("dup_n_pop", n_pop, 4);
        check("dup_dat3", pop_at(3), 32'h01020307);
        check("dup_n_done", n_done, 1);
        check("dup_done_k", done_k, 7);

        // ---------------- ReLU on/off ----------------
        drain_a(32'h40, 32'd2, 1'b1, 1'b0, 0);
        check("relu_on0", pop_at(0), 32'h00007F01);
        check("relu_on1", pop_at(1), 32'h7F00017F);
        drain_a(32'h40, 32'd2, 1'b0, 1'b0, 0);
        check("relu_off0", pop_at(0), 32'h80FF7F01);
        check("relu_off1", pop_at(1), 32'h7F80017F);

        // ---------------- clear-on-drain ----------------
        drain_a(32'h20, 32'd4, 1'b0, 1'b1, 0);
        check("clr_n_wren", n_wren, 4);
        for (int i = 0; i < 4; i++) check("clr_wadd", wadd_at(i), 32'h20 + i);
        for (int i = 0; i < 4; i++) check("clr_dat", pop_at(i), init_word(8'(8'h20 + i)));
        check("clr_bad_idat", n_bad_idat, 0);
        check("clr_done_k", done_k, 7);
        drain_a(32'h20, 32'd4, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) check("clr_redrain", pop_at(i), 32'd0);

        // ---------------- zero-length drain ----------------
        drain_a(32'h10, 32'd0, 1'b0, 1'b0, 0);
        check("zero_done_k", done_k, 1);
        check("zero_n_rden", n_rden, 0);
        check("zero_n_pop", n_pop, 0);
        check("zero_busy_after", {31'd0, busy_after}, 32'd0);

        // ---------------- MEM_DELAY=2 with backpressure ----------------
        begin
            int          kk, out_m, fifo_m, max_m, nb_pop, nb_done, stable_bad;
            logic        prev_hold;
            logic [31:0] prev_dat;
            kk = 1; out_m = 0; fifo_m = 0; max_m = 0; nb_pop = 0; nb_done = 0;
            stable_bad = 0; prev_hold = 1'b0; prev_dat = '0;
            b_base = 32'h60; b_num = 32'd16; b_start = 1'b1;
            @(posedge clk); #1;
            b_start = 1'b0;
            while (nb_done == 0 && kk < 400) begin
                b_rdy = (kk >= 5 && kk < 15) ? 1'b0 : 1'($urandom_range(0, 1));
                if (prev_hold && (!b_vld || b_dat != prev_dat)) stable_bad++;
                if (out_m + fifo_m > max_m) max_m = out_m + fifo_m;
                if (b_vld && b_rdy) begin
                    check("bp_dat", b_dat, init_word(8'(8'h60 + nb_pop)));
                    nb_pop++;
                end
                out_m  = out_m + int'(b_rden) - int'(b_ovld);
                fifo_m = fifo_m + int'(b_ovld) - int'(b_vld && b_rdy);
                prev_hold = b_vld && !b_rdy;
                prev_dat  = b_dat;
                if (b_done) nb_done++;
                @(posedge clk); #1;
                kk++;
            end
            b_rdy = 1'b1;
            check("bp_n_pop", nb_pop, 16);
            check("bp_n_done", nb_done, 1);
            check("bp_stable", stable_bad, 0);
            check("bp_max_credit_le4", {31'd0, max_m <= 4}, 32'd1);
            check("bp_done_pulse", {31'd0, b_done}, 32'd0);
        end

        // ---------------- reset mid-drain ----------------
        // Clear is on: wren at cycles 3..5 writes 0x10..0x12 back to zero;
        // the write for 0x13 would land at cycle 6 and is killed by reset.
        clear_stats();
        a_base = 32'h10; a_num = 32'd8; a_relu = 1'b0; a_clr = 1'b1; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        k = 1;
        while (k < 50) begin
            observe_a();
            if (n_pop >= 3) break;
            @(posedge clk); #1;
            k++;
        end
        check("mr_pop_k", k, 5);
        check("mr_rden_inflight", {31'd0, a_rden}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mr_radd", a_radd, 32'd0);
        check("mr_wadd", a_wadd, 32'd0);
        check("mr_odat", a_dat, 32'd0);
        check("mr_ctl", {27'd0, a_rden, a_wren, a_vld, a_busy, a_done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mr_late_ovld", {30'd0, a_vld, a_wren}, 32'd0);
        drain_a(32'h10, 32'd8, 1'b0, 1'b0, 0);
        check("mr_n_pop", n_pop, 8);
        for (int i = 0; i < 8; i++)
            check("mr_dat", pop_at(i), (i < 3) ? 32'd0 : 32'h01020304 + i);
        check("mr_n_done", n_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psum_drain_ctrl.md
# psum_drain_ctrl

Read-side counterpart of the partial-sum accumulator. Once accumulation of a layer completes, this block drains the accumulated words from the psum memory and optionally zero-clears each drained word. It applies per-lane ReLU and streams the words downstream over a valid/ready interface. It uses memory port 1 of the same psum memory, so the writer (port 0) and drainer run on independent ports.

## Interface
- BIT_WIDTH, 8: width of one kernel lane.
- NUM_KERNEL, 4: lanes per memory word; lane k occupies bits [BIT_WIDTH*(k+1)-1 : BIT_WIDTH*k].
- DATA_WIDTH, 32: memory word width; equals BIT_WIDTH*NUM_KERNEL.
- ADDR_WIDTH, 32: memory address width.
- REG_WIDTH, 32: configuration register width.
- MEM_DELAY, 1: cycles from rden to ovld; must be at least 1.
- FIFO_DEPTH, 4: output buffer depth; must be at least MEM_DELAY+2; power of two.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse; honoured only in IDLE.
- i_conf_base_addr  in  REG_WIDTH  first word address; sampled on an accepted start.
- i_conf_num_words  in  REG_WIDTH  number of words to drain; sampled on an accepted start.
- i_conf_relu_en  in  1  clamp negative signed lanes to 0; sampled on an accepted start.
- i_conf_clear_en  in  1  write 0 back to each drained address; sampled on an accepted start.
- memctrl1_radd  out  ADDR_WIDTH  read address.
- memctrl1_rden  out  1  read request.
- memctrl1_odat  in  DATA_WIDTH  read data.
- memctrl1_ovld  in  1  read data valid.
- memctrl1_wadd  out  ADDR_WIDTH  clear address.
- memctrl1_wren  out  1  clear write enable.
- memctrl1_idat  out  DATA_WIDTH  clear data; always 0.
- o_dat  out  DATA_WIDTH  output word.
- o_vld  out  1  output valid.
- i_rdy  in  1  downstream ready.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: on i_start, latch the config and set the read pointer to the base address. Go to DONE if num_words==0, otherwise go to RUN.
  - RUN: issue reads. Go to FLUSH on the cycle the last read issues.
  - FLUSH: go to DONE when outstanding==0, the FIFO is empty, and no clear write is pending.
  - DONE: assert o_done for one cycle, then return to IDLE.
- Read issue: memctrl1_rden=1 in RUN when issued_cnt < num_words and (fifo_count + outstanding) < FIFO_DEPTH. radd is the current pointer. The pointer increments by 1 per issued read. No wrap: an address overflow at 2^ADDR_WIDTH wraps modulo.
- outstanding counts reads awaiting ovld. On the same cycle, it is +1 on rden and -1 on ovld; simultaneous rden and ovld leave it unchanged.
- The address pipeline delays radd by MEM_DELAY so it aligns with ovld.
- On ovld, the word is written into the FIFO after lane processing:
  - relu_en=1: each lane is interpreted as signed; if its MSB=1, the lane becomes 0.
  - relu_en=0: data passes unchanged.
- Clear: if clear_en=1, each ovld produces wren=1 on the following cycle. wadd is the aligned address and idat=0.
- Output: the FIFO is show-ahead. o_vld = FIFO non-empty and o_dat = FIFO head. A pop occurs on o_vld&i_rdy.
  - A push and a pop in the same cycle leave the count unchanged.
  - The credit rule makes overflow impossible. A push to a full FIFO is a design error and must be flagged by an assertion.
- ovld while in IDLE or DONE is ignored: no push and no clear.
- rst at any time:
  - FSM goes to IDLE.
  - Counters, FIFO pointers, and pipelines are zeroed.
  - In-flight memory returns are dropped.
  - No o_done pulse is generated.

## Timing
- Reset values: radd=0, rden=0, wadd=0, wren=0, idat=0, o_dat=0, o_vld=0, o_busy=0, o_done=0.
- Start is accepted at cycle T. RUN is entered and o_busy=1 at T+1, and the first rden is at T+1.
- Read-to-output latency: rden at cycle t gives ovld at t+MEM_DELAY, and o_vld at t+MEM_DELAY+1. The clear write (wren) is also at t+MEM_DELAY+1.
- Throughput with i_rdy held high is one word per cycle. The FIFO depth covers the credit loop, so no bubbles occur.
- When i_rdy is low, o_dat and o_vld hold stable until the word is accepted.
- num_words=0: start at T gives o_done at T+1, with no rden.
- o_done is asserted the cycle after the last pop and the last clear write. o_busy falls together with o_done.

## Test plan
- MEM_DELAY=1. Memory holds words 0x01020304.. from base 0x10. Start with num_words=8, relu=0, clear=0, i_rdy=1. Expect:
  - 8 words out in order, back-to-back starting at T+3;
  - o_done exactly once, at the cycle after the 8th pop;
  - rden exactly 8 times.
- Word 0x80FF7F01 with relu_en=1 → output 0x00007F01. With relu_en=0 → 0x80FF7F01.
- clear_en=1, num_words=4 at base 0x20. Expect:
  - wren on addresses 0x20..0x23 with idat=0;
  - a second drain of the same range outputs all zeros.
- MEM_DELAY=2, FIFO_DEPTH=4, num_words=16, i_rdy toggling randomly and held low for 10 cycles. Expect:
  - no FIFO overflow and no word lost or duplicated;
  - outstanding+fifo_count never exceeds 4;
  - o_dat stable while o_vld&!i_rdy.
- Two further cases:
  - num_words=0 → o_done at T+1, with no rden and no o_vld.
  - A second i_start while busy → ignored.
- rst asserted mid-drain after 3 pops, with a read outstanding. Expect:
  - all outputs return to their reset values the following cycle;
  - the late ovld produces no o_vld and no wren;
  - a new start then drains correctly.
